// File: rtl/eprom_pkg.sv
// Shared constants for the boot EPROM read controller.
// Bus widths, wait-counter width, FSM state encoding, address increment.
package eprom_pkg;

    localparam int EPROM_ADDR_W = 20;
    localparam int EPROM_DATA_W = 8;
    localparam int WAIT_CNT_W   = 4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_ACCESS = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;

    function automatic logic [EPROM_ADDR_W-1:0] addr_inc(
        input logic [EPROM_ADDR_W-1:0] a
    );
        return a + 20'd1;
    endfunction

endpackage

// File: rtl/eprom_wait_timer.sv
// Loadable down-counter timing each EPROM bus phase.
// Ports: clk, reset, load, load_val -> done (count reached zero).
module eprom_wait_timer
    import eprom_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [WAIT_CNT_W-1:0] load_val,
    output logic                  done
);

    logic [WAIT_CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/eprom_read_ctrl.sv
// Boot EPROM bus master: fetch requests -> timed _cs/_oe/addr cycles.
// Ports: req_* / rsp_* handshakes, _cs, _oe, addr, data. Macro: EPROM_PREFETCH_EN.
module eprom_read_ctrl
    import eprom_pkg::*;
#(
    parameter int T_SETUP  = 1,
    parameter int T_ACCESS = 2,
    parameter int T_HOLD   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    input  logic [EPROM_ADDR_W-1:0] req_addr,
    output logic                    req_ready,
    output logic                    rsp_valid,
    output logic [EPROM_DATA_W-1:0] rsp_data,
    input  logic                    rsp_ready,
    output logic                    _cs,
    output logic                    _oe,
    output logic [EPROM_ADDR_W-1:0] addr,
    input  logic [EPROM_DATA_W-1:0] data
);

    if (T_SETUP < 1 || T_SETUP > 15 ||
        T_ACCESS < 1 || T_ACCESS > 15 ||
        T_HOLD < 1 || T_HOLD > 15) begin : g_bad_param
        $error("eprom_read_ctrl: wait states must be 1..15");
    end

    // Timer counts N-1 down to zero, so each phase lasts N cycles.
    localparam logic [WAIT_CNT_W-1:0] LD_SETUP  =
        WAIT_CNT_W'(T_SETUP - 1);
    localparam logic [WAIT_CNT_W-1:0] LD_ACCESS =
        WAIT_CNT_W'(T_ACCESS - 1);
    localparam logic [WAIT_CNT_W-1:0] LD_HOLD   =
        WAIT_CNT_W'(T_HOLD - 1);

    logic [2:0]            state;
    logic [2:0]            nstate;
    logic                  t_load;
    logic [WAIT_CNT_W-1:0] t_val;
    logic                  t_done;
    logic                  accept;
    logic                  rsp_fire;
    // Delays rsp_valid one edge past bus release.
    logic                  rsp_arm;

`ifdef EPROM_PREFETCH_EN
    logic                    is_pf;
    logic                    pf_valid;
    logic [EPROM_ADDR_W-1:0] pf_addr;
    logic [EPROM_DATA_W-1:0] pf_data;
    logic                    pf_hit;
    assign pf_hit = pf_valid && (req_addr == pf_addr);
`endif

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign rsp_fire  = rsp_valid && rsp_ready;

    eprom_wait_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (t_load),
        .load_val (t_val),
        .done     (t_done)
    );

    always_comb begin
        nstate = state;
        t_load = 1'b0;
        t_val  = '0;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    nstate = ST_SETUP;
                    t_load = 1'b1;
                    t_val  = LD_SETUP;
                end
            end
            ST_SETUP: begin
                if (t_done) begin
                    nstate = ST_ACCESS;
                    t_load = 1'b1;
                    t_val  = LD_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (t_done) begin
                    nstate = ST_HOLD;
                    t_load = 1'b1;
                    t_val  = LD_HOLD;
                end
            end
            ST_HOLD: begin
                if (t_done) begin
`ifdef EPROM_PREFETCH_EN
                    if (!is_pf) begin
                        nstate = ST_SETUP;
                        t_load = 1'b1;
                        t_val  = LD_SETUP;
                    end else if (rsp_valid && !rsp_ready) begin
                        nstate = ST_RESP;
                    end else begin
                        nstate = ST_IDLE;
                    end
`else
                    nstate = ST_RESP;
`endif
                end
            end
            ST_RESP: begin
                if (rsp_fire) begin
                    nstate = ST_IDLE;
                end
            end
            default: nstate = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            _cs       <= 1'b1;
            _oe       <= 1'b1;
            addr      <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_arm   <= 1'b0;
`ifdef EPROM_PREFETCH_EN
            is_pf     <= 1'b0;
            pf_valid  <= 1'b0;
            pf_addr   <= '0;
            pf_data   <= '0;
`endif
        end else begin
            state   <= nstate;
            _cs     <= !(nstate inside {ST_SETUP, ST_ACCESS, ST_HOLD});
            _oe     <= (nstate != ST_ACCESS);
            rsp_arm <= 1'b0;
            if (rsp_fire) begin
                rsp_valid <= 1'b0;
            end
            if (rsp_arm) begin
                rsp_valid <= 1'b1;
            end
            if (accept) begin
`ifdef EPROM_PREFETCH_EN
                pf_valid <= 1'b0;
                if (pf_hit) begin
                    rsp_data  <= pf_data;
                    rsp_valid <= 1'b1;
                    addr      <= addr_inc(req_addr);
                    is_pf     <= 1'b1;
                end else begin
                    addr  <= req_addr;
                    is_pf <= 1'b0;
                end
`else
                addr <= req_addr;
`endif
            end
            if (state == ST_ACCESS && t_done) begin
`ifdef EPROM_PREFETCH_EN
                if (is_pf) begin
                    pf_data <= data;
                end else begin
                    rsp_data <= data;
                end
`else
                rsp_data <= data;
`endif
            end
            if (state == ST_HOLD && t_done) begin
`ifdef EPROM_PREFETCH_EN
                if (!is_pf) begin
                    rsp_arm <= 1'b1;
                    addr    <= addr_inc(addr);
                    is_pf   <= 1'b1;
                end else begin
                    pf_valid <= 1'b1;
                    pf_addr  <= addr;
                end
`else
                rsp_arm <= 1'b1;
`endif
            end
        end
    end

endmodule
